// File: rtl/prio_code_pkg.sv
// prio_code_pkg: shared widths, buffer state encoding and the reference
// {V,code} -> one-hot decode used by the priority-code decoder and its bench.
package prio_code_pkg;

   localparam int PKG_CODE_W = 2;
   localparam int PKG_D_W    = 2 ** PKG_CODE_W;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } buf_state_t;

   // V=0 yields all-zero regardless of code; otherwise bit 'code' is set.
   function automatic logic [PKG_D_W-1:0] code_to_onehot(
      input logic                  v,
      input logic [PKG_CODE_W-1:0] code
   );
      logic [PKG_D_W-1:0] d;
      d = '0;
      if (v) d[code] = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/prio_skid_buf.sv
// prio_skid_buf: 2-entry (head + skid) valid/ready buffer, strict FIFO.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module prio_skid_buf
   import prio_code_pkg::*;
#(
   parameter int W = PKG_D_W + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   buf_state_t   state;
   logic [W-1:0] head;
   logic [W-1:0] skid;
   logic         ready_q;
   logic         push;
   logic         pop;

   assign in_ready  = ready_q;
   assign out_valid = (state != EMPTY);
   assign out_data  = head;
   assign push      = in_valid & ready_q;
   assign pop       = out_valid & out_ready;

   // ready_q tracks (next state != FULL); it is held low during reset
   // and rises on the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         head    <= '0;
         skid    <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               ready_q <= 1'b1;
               if (push) begin
                  head  <= in_data;
                  state <= ONE;
               end
            end
            ONE: begin
               ready_q <= 1'b1;
               if (push && pop) begin
                  head <= in_data;
               end else if (push) begin
                  skid    <= in_data;
                  state   <= FULL;
                  ready_q <= 1'b0;
               end else if (pop) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               ready_q <= 1'b0;
               if (pop) begin
                  head    <= skid;
                  state   <= ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/prio_code_decoder.sv
// prio_code_decoder: rebuilds the one-hot request vector from {V,code} and
// buffers it in a 2-entry skid buffer. Ports: clk, rst_n, in_valid/in_ready,
// in_code, in_V, out_valid/out_ready, out_D, out_V, drop_cnt.
// Option PRIO_DEC_DROP_IDLE_EN: V=0 words are accepted but discarded and
// counted in drop_cnt (saturating at 255); otherwise they pass as D=0, V=0.
module prio_code_decoder
   import prio_code_pkg::*;
#(
   parameter  int CODE_W = PKG_CODE_W,
   localparam int D_W    = 2 ** CODE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_V,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [D_W-1:0]    out_D,
   output logic              out_V,
   output logic [7:0]        drop_cnt
);

   logic [D_W-1:0] dec;
   logic           buf_valid;
   logic [D_W:0]   buf_out;

   if (CODE_W == PKG_CODE_W) begin : g_pkg_dec
      assign dec = code_to_onehot(in_V, in_code);
   end else begin : g_gen_dec
      always_comb begin
         dec = '0;
         if (in_V) dec[in_code] = 1'b1;
      end
   end

`ifdef PRIO_DEC_DROP_IDLE_EN
   logic [7:0] drop_q;

   // Idle words complete the handshake but never reach the buffer.
   assign buf_valid = in_valid & in_V;
   assign drop_cnt  = drop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else if (in_valid && in_ready && !in_V && drop_q != 8'hFF) begin
         drop_q <= drop_q + 8'd1;
      end
   end
`else
   assign buf_valid = in_valid;
   assign drop_cnt  = '0;
`endif

   prio_skid_buf #(
      .W (D_W + 1)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (buf_valid),
      .in_ready  (in_ready),
      .in_data   ({in_V, dec}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   assign out_V = buf_out[D_W];
   assign out_D = buf_out[D_W-1:0];

endmodule

// File: doc/prio_code_decoder.md
Name: prio_code_decoder

Overview:
- Inverse of the team's 4-to-2 priority encoder. Accepts encoded words {V, x, y} and rebuilds the one-hot request vector D.
- Sits downstream of an encoder across a registered link and buffers words in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Input code is {x,y} = binary index of the winning line; V=0 means no line active.

Parameters:
- CODE_W, 2, width of the encoded index {x,y}; D_W = 2**CODE_W (4 by default).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  encoded word present
- in_ready  output  1  block can accept a word this cycle
- in_code  input  CODE_W  encoded index; default bit order {x,y}, x = MSB
- in_V  input  1  encoder valid flag (any request active)
- out_valid  output  1  decoded word available
- out_ready  input  1  consumer accepts the word this cycle
- out_D  output  D_W  one-hot decoded vector; all-zero when V=0
- out_V  output  1  V flag carried with the word
- drop_cnt  output  8  saturating count of dropped V=0 words (see Optional Feature)

Behaviour:
- Decode rule:
  - out_D[i] = 1 iff V=1 and code==i; at most one bit set.
  - Default mapping: 11->D[3], 10->D[2], 01->D[1], 00->D[0].
  - V=0 -> out_D=0000, whatever the code.
- Decode is combinational on the input side. The result is stored pre-decoded ({V, D}) in the buffer. Outputs come from registers only.
- Buffer FSM states: EMPTY, ONE, FULL (2 entries: head, skid).
- Signal generation:
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY).
  - Input accepted on in_valid & in_ready. Output consumed on out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> ONE (word in head).
  - ONE: accept only -> FULL. Pop only -> EMPTY. Accept and pop together -> ONE (new word in head).
  - FULL: pop -> ONE (skid moves to head). in_ready is 0, so no accept is possible.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 word per cycle while out_ready=1.
- Ordering: strict FIFO. No word is lost or duplicated.
- Out-stall: out_D and out_V stay stable while out_valid=1 and out_ready=0.
- Reset (async assert, sync-safe release): state=EMPTY, in_ready=1 after the first clock, out_valid=0, out_D=0, out_V=0, drop_cnt=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards every buffered word.
- in_code is ignored when in_V=0.

Optional Feature:
- Macro: PRIO_DEC_DROP_IDLE_EN.
- Defined:
  - Words with in_V=0 are accepted (handshake completes) but are not written to the buffer.
  - drop_cnt increments by 1 per dropped word and saturates at 255.
  - out_V is therefore always 1 when out_valid=1.
- Undefined:
  - V=0 words pass through as out_D=0000, out_V=0.
  - drop_cnt is tied to 0.

Decomposition:
- Shared package prio_code_pkg holds:
  - CODE_W default and D_W
  - the state enum {EMPTY, ONE, FULL}
  - the decode function code_to_onehot(V, code), also used by the bench scoreboard.
- One sub-module, prio_skid_buf: the 2-entry buffer and FSM, parameterised on payload width (D_W+1).
- The top module holds the decode and the drop logic.

Test Plan:
- Sweep: reset, then out_ready=1 and drive all 8 {V,code} values in one burst -> out_D sequence 0000,0000,0000,0000,0001,0010,0100,1000 (V=0 first), each 1 cycle after accept; out_V matches.
- Backpressure:
  - out_ready=0, push codes 11 then 01 with V=1 -> in_ready drops to 0 after the second accept; out_D holds 1000.
  - Then raise out_ready -> 1000 then 0010 appear on consecutive cycles, and in_ready returns to 1.
- Simultaneous push/pop in ONE: alternate codes 10/00 at full rate with out_ready=1 -> state stays ONE, outputs 0100,0001 repeating, no bubbles.
- Reset mid-operation: buffer FULL, assert rst_n=0 asynchronously between clock edges -> out_valid=0 and out_D=0000 immediately; after release the first new word decodes correctly.
- PRIO_DEC_DROP_IDLE_EN defined: push 300 V=0 words interleaved with code 10 V=1 -> only 0100 words emerge, and drop_cnt saturates at 255.
- Random: 10k cycles of random in_valid/out_ready against a reference queue and code_to_onehot -> zero mismatches, and one-hot holds on every valid output.
